// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM encoding, default width and
// the quotient pattern reported on divide-by-zero.
package arith_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

   localparam int DIV_DEFAULT_W = 16;

   // All-ones quotient on divide-by-zero; sliced to the divider width (up to 64 bits).
   localparam logic [63:0] DIV_DBZ_Q = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,q} left by one and subtract the divisor
// from the widened remainder, keeping the difference only when it is non-negative.
module div_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] rem_in,
   input  logic [W-1:0] q_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic [W-1:0] q_out
);

   logic [W:0] rs;
   logic [W:0] trial;

   // rem_in < divisor always holds, so rs < 2*divisor and bit W of the
   // (W+1)-bit difference is a valid sign bit.
   always_comb begin
      rs    = {rem_in, q_in[W-1]};
      trial = rs - {1'b0, divisor};
      if (!trial[W]) begin
         rem_out = trial[W-1:0];
         q_out   = {q_in[W-2:0], 1'b1};
      end else begin
         rem_out = rs[W-1:0];
         q_out   = {q_in[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div16_seq.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV16_SIGNED_EN for two's-complement operands (adds a sign fix-up cycle).
module div16_seq
   import arith_pkg::*;
#(
   parameter  int DATA_W = DIV_DEFAULT_W,
   localparam int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              div_by_zero,
   output logic              busy
);

   div_state_t        state, state_d;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem_r, q_r, dvs_r;
   logic [DATA_W-1:0] step_rem, step_q;
   logic [DATA_W-1:0] opa, opb;
   logic              zdiv, accept, last, ov_d;

`ifdef DIV16_SIGNED_EN
   logic qneg, rneg;
   assign opa = dividend[DATA_W-1] ? -dividend : dividend;
   assign opb = divisor[DATA_W-1]  ? -divisor  : divisor;
`else
   assign opa = dividend;
   assign opb = divisor;
`endif

   assign accept   = in_valid && (state == S_IDLE);
   assign last     = (cnt == CNT_W'(DATA_W - 1));
   assign in_ready = (state == S_IDLE);
   assign busy     = (state == S_CALC) || (state == S_FIX);

   div_step #(.W(DATA_W)) u_step (
      .rem_in  (rem_r),
      .q_in    (q_r),
      .divisor (dvs_r),
      .rem_out (step_rem),
      .q_out   (step_q)
   );

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE: if (accept) state_d = (divisor == '0) ? S_DONE : S_CALC;
         S_CALC: begin
            if (last) begin
`ifdef DIV16_SIGNED_EN
               state_d = S_FIX;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_FIX:  state_d = S_DONE;
         S_DONE: if (out_valid && out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A divide-by-zero enters DONE straight from IDLE; its result is published one cycle later.
   assign ov_d = (state_d == S_DONE) && (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rem_r       <= '0;
         q_r         <= '0;
         dvs_r       <= '0;
         zdiv        <= 1'b0;
         out_valid   <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
`ifdef DIV16_SIGNED_EN
         qneg        <= 1'b0;
         rneg        <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         out_valid   <= ov_d;
         div_by_zero <= ov_d && zdiv;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt   <= '0;
                  rem_r <= '0;
                  q_r   <= opa;
                  dvs_r <= opb;
                  zdiv  <= (divisor == '0);
`ifdef DIV16_SIGNED_EN
                  qneg  <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
                  rneg  <= dividend[DATA_W-1];
`endif
                  if (divisor == '0) begin
                     quotient  <= DIV_DBZ_Q[DATA_W-1:0];
                     remainder <= dividend;
                  end
               end
            end
            S_CALC: begin
               rem_r <= step_rem;
               q_r   <= step_q;
               cnt   <= last ? '0 : cnt + 1'b1;
`ifndef DIV16_SIGNED_EN
               if (last) begin
                  quotient  <= step_q;
                  remainder <= step_rem;
               end
`endif
            end
            S_FIX: begin
`ifdef DIV16_SIGNED_EN
               // Truncating division: remainder follows the dividend's sign.
               quotient  <= qneg ? -q_r : q_r;
               remainder <= rneg ? -rem_r : rem_r;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed vector table, hold/reset corner cases,
// and randomized operations against an arithmetic reference model.
module tb_div16_seq;

   localparam int W = 16;
`ifdef DIV16_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         in_ready, out_valid, div_by_zero, busy;
   logic [W-1:0] quotient, remainder;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
      int           hold;
   } vec_t;

   vec_t tbl[6];

   div16_seq #(.DATA_W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic z, output int lat);
      if (b == '0) begin
         q   = '1;
         r   = a;
         z   = 1'b1;
         lat = 1;
      end else begin
`ifdef DIV16_SIGNED_EN
         int sa, sb, qi, ri;
         sa = int'($signed(a));
         sb = int'($signed(b));
         qi = sa / sb;
         ri = sa % sb;
         q  = W'(qi);
         r  = W'(ri);
`else
         q = a / b;
         r = a % b;
`endif
         z   = 1'b0;
         lat = LAT;
      end
   endfunction

   // Called 1 time unit after a rising edge with the divider idle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int elat, input int hold, input string tag);
      int   lat;
      logic rdy_seen, stable;
      chk({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      dividend  = a;
      divisor   = b;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat = 0;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 60) begin
         rdy_seen |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      rdy_seen |= in_ready;
      chk({tag, ".latency"}, 32'(lat), 32'(elat));
      chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
      chk({tag, ".remainder"}, 32'(remainder), 32'(er));
      chk({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
      chk({tag, ".rdy_low_busy"}, 32'(rdy_seen), 32'd0);
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         dividend = W'($urandom);
         divisor  = W'($urandom_range(0, 3));
         @(posedge clk); #1;
         if (!out_valid || in_ready || quotient !== eq || remainder !== er || div_by_zero !== ez)
            stable = 1'b0;
      end
      in_valid = 1'b0;
      if (hold > 0) chk({tag, ".hold_stable"}, 32'(stable), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
      chk({tag, ".dbz_drop"}, 32'(div_by_zero), 32'd0);
      chk({tag, ".q_keep"}, 32'(quotient), 32'(eq));
      chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [W-1:0] a, b, q, r;
      logic         z;
      int           lat;

`ifdef DIV16_SIGNED_EN
      tbl[0] = '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, LAT, 0};
      tbl[1] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, LAT, 0};
      tbl[2] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1,   0};
      tbl[3] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, LAT, 0};
      tbl[4] = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, LAT, 5};
      tbl[5] = '{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, LAT, 2};
`else
      tbl[0] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, LAT, 0};
      tbl[1] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1,   0};
      tbl[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, LAT, 0};
      tbl[3] = '{16'h0003, 16'h0007, 16'h0000, 16'h0003, 1'b0, LAT, 0};
      tbl[4] = '{16'h00C8, 16'h0009, 16'h0016, 16'h0002, 1'b0, LAT, 5};
      tbl[5] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, LAT, 2};
`endif

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.dbz", 32'(div_by_zero), 32'd0);
      chk("rst.quotient", 32'(quotient), 32'd0);
      chk("rst.remainder", 32'(remainder), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i])
         run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].lat, tbl[i].hold,
                $sformatf("vec%0d", i));

      // Reset in the middle of a computation.
      in_valid = 1'b1;
      dividend = 16'hFFFF;
      divisor  = 16'h0003;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("midrst.busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst.in_ready", 32'(in_ready), 32'd1);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.out_valid", 32'(out_valid), 32'd0);
      chk("midrst.dbz", 32'(div_by_zero), 32'd0);
      chk("midrst.quotient", 32'(quotient), 32'd0);
      chk("midrst.remainder", 32'(remainder), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, LAT, 0, "post_rst");

      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         if ($urandom_range(0, 7) == 0)      b = '0;
         else if ($urandom_range(0, 1) != 0) b = W'($urandom);
         else                                b = W'($urandom_range(1, 15));
         model(a, b, q, r, z, lat);
         run_op(a, b, q, r, z, lat, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
